// File: rtl/demux4_tdm_if.sv
// demux4_tdm_if: serial TDM input beats and the published frame, lock, slot, error and count outputs
interface demux4_tdm_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic             valid;
  logic             sync;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             frame_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             err;
  logic [7:0]       frame_cnt;
  modport master (
    output din, valid, sync,
    input  y0, y1, y2, y3, frame_valid, locked, slot, err, frame_cnt
  );
  modport slave (
    input  din, valid, sync,
    output y0, y1, y2, y3, frame_valid, locked, slot, err, frame_cnt
  );
endinterface

// File: rtl/demux4_tdm.sv
// demux4_tdm: locks onto channel-0 sync and publishes four TDM channel words per completed frame
module demux4_tdm #(parameter int WIDTH = 4) (
  input logic         clk,
  input logic         rst_n,
  demux4_tdm_if.slave bus
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t           state;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= HUNT;
      sh0             <= '0;
      sh1             <= '0;
      sh2             <= '0;
      bus.y0          <= '0;
      bus.y1          <= '0;
      bus.y2          <= '0;
      bus.y3          <= '0;
      bus.frame_valid <= 1'b0;
      bus.locked      <= 1'b0;
      bus.slot        <= 2'd0;
      bus.err         <= 1'b0;
      bus.frame_cnt   <= 8'd0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.err         <= 1'b0;
      if (bus.valid) begin
        if (state == HUNT) begin
          if (bus.sync) begin
            sh0        <= bus.din;
            bus.slot   <= 2'd1;
            state      <= LOCK;
            bus.locked <= 1'b1;
          end
        end else if (bus.sync) begin
          // an early sync drops the partial frame and restarts on this beat
          bus.err  <= bus.slot != 2'd0;
          sh0      <= bus.din;
          bus.slot <= 2'd1;
        end else if (bus.slot == 2'd0) begin
          bus.err    <= 1'b1;
          state      <= HUNT;
          bus.locked <= 1'b0;
        end else if (bus.slot == 2'd3) begin
          bus.y0          <= sh0;
          bus.y1          <= sh1;
          bus.y2          <= sh2;
          bus.y3          <= bus.din;
          bus.frame_valid <= 1'b1;
          bus.frame_cnt   <= bus.frame_cnt + 8'd1;
          bus.slot        <= 2'd0;
        end else begin
          if (bus.slot == 2'd1) sh1 <= bus.din;
          else sh2 <= bus.din;
          bus.slot <= bus.slot + 2'd1;
        end
      end
    end
  end
endmodule

// File: doc/demux4_tdm.md
# demux4_tdm

Four-channel time-division demultiplexer. It is the receive end of a link where a 4:1 word multiplexer rotates through channels 0..3, one word per valid beat, and flags channel 0 with a sync strobe. The block locks onto the sync, steers each beat into a per-channel shadow register, and publishes all four channel words together once a full frame is captured. It also reports lock status, framing errors and a frame count.

## Interface
Parameters:
- WIDTH, 4: channel word width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  WIDTH  serialized channel word.
- valid  input  1  din/sync qualify this cycle; low = stall, no state change.
- sync  input  1  marks the beat carrying channel 0; only meaningful with valid.
- y0, y1, y2, y3  output  WIDTH each  registered channel words from the last complete frame.
- frame_valid  output  1  one-cycle pulse when y0..y3 update.
- locked  output  1  high in LOCK state.
- slot  output  2  index of the channel expected on the next valid beat.
- err  output  1  one-cycle pulse on a framing error.
- frame_cnt  output  8  completed frames, modulo 256.

## Operation
- Reset (rst_n low at a clock edge): y0..y3=0, frame_valid=0, locked=0, slot=0, err=0, frame_cnt=0, shadow registers=0, state=HUNT. Reset overrides every other input in that cycle. A partial frame is discarded.
- State machine: HUNT, LOCK.
- HUNT:
  - Beats with valid=1 and sync=0 are discarded.
  - valid=1 with sync=1: shadow0<=din, slot<=1, go to LOCK.
- LOCK, valid=1 beats:
  - sync=0 with slot in 1..2: shadow[slot]<=din, slot<=slot+1.
  - sync=0 with slot=3: y0<=shadow0, y1<=shadow1, y2<=shadow2, y3<=din, frame_valid pulse, frame_cnt<=frame_cnt+1 (255 wraps to 0), slot<=0.
  - sync=1 with slot=0: normal frame start. shadow0<=din, slot<=1.
  - sync=1 with slot≠0 (early sync): err pulse, partial frame dropped. Resynchronise immediately: shadow0<=din, slot<=1, stay in LOCK.
  - sync=0 with slot=0 (missing sync): err pulse, beat discarded, slot<=0, go to HUNT.
- valid=0 in any state: nothing changes. frame_valid and err are 0 because they are single-cycle pulses.
- y0..y3 change only on a frame completion and keep their value across errors, HUNT periods and stalls.
- frame_valid and err are never both high: completion requires sync=0 at slot 3, while errors require the other cases.

## Timing
- Every output is a register. There are no combinational paths from inputs to outputs.
- Latency: the 4th beat (slot 3) is sampled at edge N. After edge N, y0..y3 hold the new frame and frame_valid=1 for exactly one cycle (edge N to N+1).
- err is high for exactly one cycle after the edge that sampled the offending beat.
- locked rises after the edge that samples the first valid&sync in HUNT. It falls after the edge that samples a missing-sync beat.
- slot always reflects the post-edge expectation.
- Throughput: with valid held high and correct sync, one frame every 4 cycles, back-to-back, with no bubbles.
- Stalls: any number of valid=0 cycles is allowed between beats, including mid-frame. The frame still completes correctly.

## Test plan
- Basic frame:
  - Stimulus: after reset, valid=1 beats din=1(sync),2,2,3.
  - Required: frame_valid pulses once; y0=1, y1=2, y2=2, y3=3; frame_cnt=1; locked=1; slot=0.
- Stall mid-frame:
  - Stimulus: beats 4(sync),5, then valid=0 for 3 cycles, then 6,7.
  - Required: no frame_valid during the stall; then y=4,5,6,7; frame_cnt increments by 1.
- Early sync:
  - Stimulus: 8(sync),9, then A(sync),B,C,D.
  - Required: err pulse on the A beat; no frame_valid for 8/9; then y=A,B,C,D; locked stays 1.
- Missing sync, reset mid-frame:
  - Stimulus: a complete frame, then a 5th beat with sync=0, then 1(sync),2, then rst_n=0 for one edge.
  - Required: err pulse on the 5th beat and locked=0; after reset, all outputs are 0 and state is HUNT.
- Wraparound:
  - Stimulus: 256 back-to-back valid frames.
  - Required: frame_cnt returns to 0; frame_valid pulses 256 times, every 4th cycle; no err.
